// File: rtl/controller_fsm.sv
// Multicycle CPU control unit: fetch/decode/execute sequencing with memory handshakes.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module controller_fsm (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  opcode,
   input  logic [3:0]  opext,
   input  logic        cond_true,
   input  logic        mem_ready,
   output logic        irwrite,
   output logic        pcen,
   output logic [1:0]  pcsrc,
   output logic        iord,
   output logic        memread,
   output logic        memwrite,
   output logic        regwrite,
   output logic        memtoreg,
   output logic        linkwrite,
   output logic        alusrcb,
   output logic [3:0]  state,
   output logic [15:0] instret
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC   = 4'd2,
      ALUWB  = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      JUMP   = 4'd7,
      BRANCH = 4'd8
   } state_t;

   state_t r_state;
   state_t w_next;

   logic w_isLoad;
   logic w_isStor;
   logic w_isJal;
   logic w_isJcond;
   logic w_isBcond;
   logic w_isCmp;
   logic w_immB;

   assign w_isLoad  = (opcode == 4'b0100) && (opext == 4'b0000);
   assign w_isStor  = (opcode == 4'b0100) && (opext == 4'b0100);
   assign w_isJal   = (opcode == 4'b0100) && (opext == 4'b1000);
   assign w_isJcond = (opcode == 4'b0100) && (opext == 4'b1100);
   assign w_isBcond = (opcode == 4'b1100);
   assign w_isCmp   = (opcode == 4'b1011) || ((opcode == 4'b0000) && (opext == 4'b1011));
   assign w_immB    = (opcode != 4'b0000);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_next;
   end

   // Outputs are held at zero for the whole of reset, even though the state is FETCH
   always_comb begin
      w_next    = FETCH;
      irwrite   = 1'b0;
      pcen      = 1'b0;
      pcsrc     = 2'b00;
      iord      = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      regwrite  = 1'b0;
      memtoreg  = 1'b0;
      linkwrite = 1'b0;
      alusrcb   = 1'b0;
      if (!reset) begin
         case (r_state)
            FETCH: begin
               memread = 1'b1;
               if (mem_ready) begin
                  irwrite = 1'b1;
                  pcen    = 1'b1;
                  w_next  = DECODE;
               end else begin
                  w_next  = FETCH;
               end
            end
            DECODE: begin
               if (w_isLoad)                  w_next = MEMRD;
               else if (w_isStor)             w_next = MEMWR;
               else if (w_isJal || w_isJcond) w_next = JUMP;
               else if (w_isBcond)            w_next = BRANCH;
               else                           w_next = EXEC;
            end
            EXEC: begin
               alusrcb = w_immB;
               w_next  = ALUWB;
            end
            ALUWB: begin
               alusrcb  = w_immB;
               regwrite = !w_isCmp;
            end
            MEMRD: begin
               memread = 1'b1;
               iord    = 1'b1;
               w_next  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
               regwrite = 1'b1;
               memtoreg = 1'b1;
            end
            MEMWR: begin
               memwrite = 1'b1;
               iord     = 1'b1;
               w_next   = mem_ready ? FETCH : MEMWR;
            end
            JUMP: begin
               if (w_isJal || cond_true) begin
                  pcen  = 1'b1;
                  pcsrc = 2'b10;
               end
               linkwrite = w_isJal;
               regwrite  = w_isJal;
            end
            BRANCH: begin
               if (cond_true) begin
                  pcen  = 1'b1;
                  pcsrc = 2'b01;
               end
            end
            default: w_next = FETCH;
         endcase
      end
   end

   assign state = r_state;

`ifdef PERF_CNT_EN
   logic [15:0] r_instret;

   // An instruction retires on every return to FETCH; wraps naturally at 16 bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_instret <= 16'd0;
      else if ((r_state != FETCH) && (w_next == FETCH))
         r_instret <= r_instret + 16'd1;
   end

   assign instret = r_instret;
`else
   assign instret = 16'd0;
`endif

endmodule
